// File: rtl/pmp_csr_sequencer_if.sv
// CSR access port between the PMP programming sequencer (master) and the pmp
// block (slave). One access per cycle: wr_en or rd_en with rw_addr; write data
// on wdata, read data returned on rdata the cycle after rd_en.
//   wr_en   : write strobe
//   rd_en   : read strobe
//   rw_addr : CSR address
//   wdata   : write data
//   rdata   : read data
interface pmp_csr_sequencer_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] rw_addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wr_en, rd_en, rw_addr, wdata, input rdata);
   modport slave  (input wr_en, rd_en, rw_addr, wdata, output rdata);
endinterface

// File: rtl/pmp_csr_sequencer.sv
// PMP CSR programming sequencer. Holds NUM_REGIONS {pmpaddr, pmpcfg} entries and,
// on start, writes every pmpaddr CSR followed by every packed pmpcfg word, one
// CSR access per cycle, then pulses done.
// Optional feature macro: PMP_SEQ_VERIFY_EN -- reads back each pmpcfg word and
// flags the first mismatch on error/err_idx.
// Ports:
//   clock, reset      : clock (rising edge), asynchronous active-high reset
//   tbl_we/idx/addr/cfg : table load port (acted on only while idle)
//   start             : begin sequence (level, sampled while idle)
//   busy, done        : sequence in progress / one-cycle completion pulse
//   error, err_idx    : readback mismatch flag and cfg word index
//   csr               : CSR access port to the pmp block (master side)
module pmp_csr_sequencer #(
   parameter int unsigned NUM_REGIONS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tbl_we,
   input  logic [3:0]  tbl_idx,
   input  logic [31:0] tbl_addr,
   input  logic [7:0]  tbl_cfg,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_idx,
   pmp_csr_sequencer_if.master csr
);

   localparam int unsigned CW        = $clog2(NUM_REGIONS);
   localparam int unsigned NUM_WORDS = NUM_REGIONS / 4;
   localparam logic [CW-1:0] LAST_REG  = CW'(NUM_REGIONS - 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
   localparam logic [31:0] CSR_PMPADDR0 = 32'h0000_03B0;
   localparam logic [31:0] CSR_PMPCFG0  = 32'h0000_03A0;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_ADDR = 3'd1;
   localparam logic [2:0] S_WR_CFG  = 3'd2;
`ifdef PMP_SEQ_VERIFY_EN
   localparam logic [2:0] S_RB_REQ  = 3'd3;
   localparam logic [2:0] S_RB_CHK  = 3'd4;
`endif
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]    state_q, state_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          wr_en_q, wr_en_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic [31:0]   rw_addr_q, rw_addr_nxt;
   logic [31:0]   wdata_q, wdata_nxt;

   logic [31:0]   addr_tbl [NUM_REGIONS];
   logic [7:0]    cfg_tbl  [NUM_REGIONS];
   logic [31:0]   cfg_words [4];
   logic          tbl_wr;
   logic [CW-1:0] tbl_sel;

   // Table writes are accepted only while idle and for in-range indices
   assign tbl_sel = tbl_idx[CW-1:0];
   assign tbl_wr  = tbl_we && (state_q == S_IDLE) && (32'(tbl_idx) < NUM_REGIONS);

   // Region table
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGIONS; r++) begin
            addr_tbl[CW'(r)] <= '0;
            cfg_tbl[CW'(r)]  <= '0;
         end
      end else if (tbl_wr) begin
         addr_tbl[tbl_sel] <= tbl_addr;
         cfg_tbl[tbl_sel]  <= tbl_cfg;
      end
   end

   // Pack four cfg bytes per pmpcfg word, lowest entry in the low byte
   always_comb begin
      cfg_words = '{default: '0};
      for (int w = 0; w < NUM_WORDS; w++) begin
         for (int b = 0; b < 4; b++) begin
            cfg_words[w][8*b +: 8] = cfg_tbl[CW'(4*w + b)];
         end
      end
   end

`ifdef PMP_SEQ_VERIFY_EN
   logic       error_q, error_nxt;
   logic [1:0] err_idx_q, err_idx_nxt;
   logic       rd_en_q, rd_en_nxt;
`else
   logic unused_rdata;
   assign unused_rdata = ^csr.rdata;
`endif

   // Next state, counter and registered-output values
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
`ifdef PMP_SEQ_VERIFY_EN
      error_nxt   = error_q;
      err_idx_nxt = err_idx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_WR_ADDR;
               cnt_nxt   = '0;
`ifdef PMP_SEQ_VERIFY_EN
               error_nxt   = 1'b0;
               err_idx_nxt = 2'd0;
`endif
            end
         end
         S_WR_ADDR: begin
            if (cnt_q == LAST_REG) begin
               state_nxt = S_WR_CFG;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         S_WR_CFG: begin
            if (cnt_q == LAST_WORD) begin
`ifdef PMP_SEQ_VERIFY_EN
               state_nxt = S_RB_REQ;
               cnt_nxt   = '0;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
`ifdef PMP_SEQ_VERIFY_EN
         S_RB_REQ: state_nxt = S_RB_CHK;
         S_RB_CHK: begin
            // First mismatch aborts the remaining readbacks
            if (csr.rdata != cfg_words[cnt_q[1:0]]) begin
               error_nxt   = 1'b1;
               err_idx_nxt = cnt_q[1:0];
               state_nxt   = S_DONE;
            end else if (cnt_q == LAST_WORD) begin
               state_nxt = S_DONE;
            end else begin
               cnt_nxt   = cnt_q + CW'(1);
               state_nxt = S_RB_REQ;
            end
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they register in step with it
      wr_en_nxt   = (state_nxt == S_WR_ADDR) || (state_nxt == S_WR_CFG);
      done_nxt    = (state_nxt == S_DONE);
      busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      rw_addr_nxt = '0;
      wdata_nxt   = '0;
`ifdef PMP_SEQ_VERIFY_EN
      rd_en_nxt   = (state_nxt == S_RB_REQ);
      if (state_nxt == S_RB_REQ) begin
         rw_addr_nxt = CSR_PMPCFG0 + 32'(cnt_nxt);
      end
`endif
      if (state_nxt == S_WR_ADDR) begin
         rw_addr_nxt = CSR_PMPADDR0 + 32'(cnt_nxt);
         // A load in the start cycle must reach the first address write
         wdata_nxt   = (tbl_wr && (tbl_sel == cnt_nxt)) ? tbl_addr : addr_tbl[cnt_nxt];
      end else if (state_nxt == S_WR_CFG) begin
         rw_addr_nxt = CSR_PMPCFG0 + 32'(cnt_nxt);
         wdata_nxt   = cfg_words[cnt_nxt[1:0]];
      end
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rw_addr_q <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         wr_en_q   <= wr_en_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         rw_addr_q <= rw_addr_nxt;
         wdata_q   <= wdata_nxt;
      end
   end

`ifdef PMP_SEQ_VERIFY_EN
   // Readback strobe and sticky mismatch report
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_en_q   <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= 2'd0;
      end else begin
         rd_en_q   <= rd_en_nxt;
         error_q   <= error_nxt;
         err_idx_q <= err_idx_nxt;
      end
   end

   assign csr.rd_en = rd_en_q;
   assign error     = error_q;
   assign err_idx   = err_idx_q;
`else
   assign csr.rd_en = 1'b0;
   assign error     = 1'b0;
   assign err_idx   = 2'd0;
`endif

   assign csr.wr_en   = wr_en_q;
   assign csr.rw_addr = rw_addr_q;
   assign csr.wdata   = wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
